// File: rtl/hop_seq_ctrl_pkg.sv
// Shared constants for the Hopfield sequencing controller: default geometry
// and FSM state encodings.
package hop_seq_ctrl_pkg;

   localparam int unsigned DEF_SIZE = 8;
   localparam int unsigned DEF_N    = 8;
   localparam int unsigned ITER_W   = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_RUN     = 3'd2,
      ST_CHECK   = 3'd3,
      ST_SEND    = 3'd4,
      ST_WAIT_TX = 3'd5,
      ST_ERR     = 3'd6
   } state_e;

endpackage

// File: rtl/hop_timeout_cnt.sv
// Loadable down-counter; expire_c flags the last allowed cycle while enabled.
module hop_timeout_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expire_c
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   // Independent of load so the parent's next-state logic stays loop-free.
   assign expire_c = en && (cnt_q == '0);

endmodule

// File: rtl/hop_seq_ctrl.sv
// Sequencer around a Hopfield network: collects an input pattern from RX
// frames, iterates the network until a fixed point or MAX_ITER, then sends it.
module hop_seq_ctrl
   import hop_seq_ctrl_pkg::*;
#(
   parameter int unsigned SIZE     = DEF_SIZE,
   parameter int unsigned N        = DEF_N,
   parameter int unsigned FRAMES   = 2,
   parameter int unsigned MAX_ITER = 16,
   parameter int unsigned TIMEOUT  = 65535
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                abort,
   input  logic                rx_done,
   input  logic [N*SIZE-1:0]   rx_data,
   output logic                net_en,
   output logic [N*SIZE-1:0]   net_s,
   input  logic                net_done,
   input  logic [N*SIZE-1:0]   net_res,
   output logic                tx_en,
   output logic [N*SIZE-1:0]   tx_data,
   input  logic                tx_done,
   output logic                busy,
   output logic                converged,
   output logic                err,
   output logic                overrun,
   output logic [ITER_W-1:0]   iter,
   output logic                done
);

   localparam int unsigned W  = N * SIZE;
   localparam int unsigned FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   state_e              fsm_q, fsm_d;
   logic [W-1:0]        state_q, state_d;
   logic [W-1:0]        tx_data_q, tx_data_d;
   logic [FW-1:0]       frame_cnt_q, frame_cnt_d;
   logic [ITER_W-1:0]   iter_q, iter_d;
   logic                net_en_q, net_en_d;
   logic                tx_en_q, tx_en_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic                converged_q, converged_d;
   logic                err_q, err_d;
   logic                overrun_q, overrun_d;
   logic                tmo_load_c, tmo_en_c, tmo_expire_c;
   logic [ITER_W-1:0]   iter_inc_c;

   assign iter_inc_c = iter_q + ITER_W'(1);
   assign tmo_en_c   = (fsm_q == ST_RUN) || (fsm_q == ST_WAIT_TX);

   hop_timeout_cnt #(.W(TW)) u_tmo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (abort),
      .load     (tmo_load_c),
      .load_val (TW'(TIMEOUT - 1)),
      .en       (tmo_en_c),
      .expire_c (tmo_expire_c)
   );

   // Next-state and registered-output logic; abort overrides every event.
   always_comb begin
      fsm_d       = fsm_q;
      state_d     = state_q;
      tx_data_d   = tx_data_q;
      frame_cnt_d = frame_cnt_q;
      iter_d      = iter_q;
      converged_d = converged_q;
      err_d       = err_q;
      overrun_d   = overrun_q;
      done_d      = 1'b0;

      if (abort) begin
         fsm_d       = ST_IDLE;
         frame_cnt_d = '0;
         err_d       = 1'b0;
         overrun_d   = 1'b0;
      end else begin
         if (rx_done && (fsm_q != ST_IDLE) && (fsm_q != ST_COLLECT)) overrun_d = 1'b1;
         case (fsm_q)
            ST_IDLE, ST_COLLECT: begin
               if (rx_done) begin
                  state_d = rx_data;
                  if (frame_cnt_q == FW'(FRAMES - 1)) begin
                     frame_cnt_d = '0;
                     iter_d      = '0;
                     converged_d = 1'b0;
                     fsm_d       = ST_RUN;
                  end else begin
                     frame_cnt_d = frame_cnt_q + FW'(1);
                     fsm_d       = ST_COLLECT;
                  end
               end
            end
            ST_RUN: begin
               if (net_done) begin
                  fsm_d = ST_CHECK;
               end else if (tmo_expire_c) begin
                  fsm_d = ST_ERR;
                  err_d = 1'b1;
               end
            end
            ST_CHECK: begin
               iter_d = iter_inc_c;
               if (net_res == state_q) begin
                  converged_d = 1'b1;
                  tx_data_d   = net_res;
                  fsm_d       = ST_SEND;
               end else if (iter_inc_c == ITER_W'(MAX_ITER)) begin
                  converged_d = 1'b0;
                  tx_data_d   = net_res;
                  fsm_d       = ST_SEND;
               end else begin
                  state_d = net_res;
                  fsm_d   = ST_RUN;
               end
            end
            ST_SEND: fsm_d = ST_WAIT_TX;
            ST_WAIT_TX: begin
               if (tx_done) begin
                  done_d = 1'b1;
                  fsm_d  = ST_IDLE;
               end else if (tmo_expire_c) begin
                  fsm_d = ST_ERR;
                  err_d = 1'b1;
               end
            end
            ST_ERR:  fsm_d = ST_ERR;
            default: fsm_d = ST_IDLE;
         endcase
      end

      net_en_d   = (fsm_d == ST_RUN);
      tx_en_d    = (fsm_d == ST_SEND);
      busy_d     = (fsm_d != ST_IDLE);
      tmo_load_c = ((fsm_d == ST_RUN) || (fsm_d == ST_WAIT_TX)) && (fsm_d != fsm_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q       <= ST_IDLE;
         state_q     <= '0;
         tx_data_q   <= '0;
         frame_cnt_q <= '0;
         iter_q      <= '0;
         net_en_q    <= 1'b0;
         tx_en_q     <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         converged_q <= 1'b0;
         err_q       <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         state_q     <= state_d;
         tx_data_q   <= tx_data_d;
         frame_cnt_q <= frame_cnt_d;
         iter_q      <= iter_d;
         net_en_q    <= net_en_d;
         tx_en_q     <= tx_en_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         converged_q <= converged_d;
         err_q       <= err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign net_en    = net_en_q;
   assign net_s     = state_q;
   assign tx_en     = tx_en_q;
   assign tx_data   = tx_data_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign converged = converged_q;
   assign err       = err_q;
   assign overrun   = overrun_q;
   assign iter      = iter_q;

endmodule

// File: doc/hop_seq_ctrl.md
HOP_SEQ_CTRL -- requirements
Module: hop_seq_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 8: bit width of one neuron state element.
REQ-002 SHALL have parameter N, default 8: number of neurons; state vector width is N*SIZE.
REQ-003 SHALL have parameter FRAMES, default 2: number of rx_done pulses that make up one input pattern.
REQ-004 SHALL have parameter MAX_ITER, default 16: maximum number of net update passes per pattern (range 1..255).
REQ-005 SHALL have parameter TIMEOUT, default 65535: maximum cycles allowed in RUN or WAIT_TX.
REQ-006 SHALL have port clk  in  1: clock.
REQ-007 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-008 SHALL have port abort  in  1: synchronous return to IDLE.
REQ-009 SHALL have port rx_done  in  1: one-cycle pulse, RX frame complete.
REQ-010 SHALL have port rx_data  in  N*SIZE: received pattern.
REQ-011 SHALL have port net_en  out  1: level enable to the network.
REQ-012 SHALL have port net_s  out  N*SIZE: current state vector driven to the network.
REQ-013 SHALL have port net_done  in  1: network pass complete.
REQ-014 SHALL have port net_res  in  N*SIZE: network result.
REQ-015 SHALL have port tx_en  out  1: one-cycle pulse, start UART transmit.
REQ-016 SHALL have port tx_data  out  N*SIZE: registered result for TX.
REQ-017 SHALL have port tx_done  in  1: TX complete.
REQ-018 SHALL have ports busy, converged, err, overrun  out  1 each; iter  out  8; done  out  1 (one-cycle pulse).

Function
REQ-019 SHALL implement FSM states IDLE, COLLECT, RUN, CHECK, SEND, WAIT_TX, ERR.
REQ-020 SHALL, in IDLE/COLLECT, on each rx_done: latch rx_data into state_q and increment frame_cnt; first pulse moves IDLE->COLLECT.
REQ-021 SHALL, on the FRAMES-th rx_done, enter RUN with iter=0 and frame_cnt=0; net_en high the next cycle; FRAMES=1 goes IDLE->RUN directly.
REQ-022 SHALL hold net_en=1 only in RUN; net_s=state_q at all times.
REQ-023 SHALL, in RUN, go to CHECK on net_done (net_en low in CHECK).
REQ-024 SHALL, in CHECK (exactly 1 cycle): iter<=iter+1; if net_res==state_q -> converged=1, SEND; else if iter+1==MAX_ITER -> converged=0, SEND; else state_q<=net_res, RUN.
REQ-025 SHALL, in SEND: tx_data<=net_res, tx_en=1 for exactly one cycle, then WAIT_TX; latency net_done->tx_en is 2 cycles.
REQ-026 SHALL, in WAIT_TX on tx_done: pulse done for one cycle and return to IDLE; converged and iter hold until the next pattern starts.
REQ-027 SHALL count cycles in RUN and WAIT_TX (counter cleared on state entry); reaching TIMEOUT -> ERR with err=1; net_done/tx_done in the same cycle wins over timeout.
REQ-028 SHALL remain in ERR until abort; busy=1 in every state except IDLE.
REQ-029 SHALL ignore rx_done outside IDLE/COLLECT and set sticky overrun.
REQ-030 SHALL, on abort in any state, return to IDLE next cycle, clearing frame_cnt, err, overrun and the timeout counter; abort has priority over all other events.

Reset
REQ-031 SHALL, on rst_n low, asynchronously force IDLE, with net_en=0, tx_en=0, done=0, busy=0, converged=0, err=0, overrun=0, iter=0, state_q=0, tx_data=0, and all counters=0.

Structure
REQ-032 SHALL take SIZE/N defaults and FSM state encodings from the shared constants header.
REQ-033 SHALL contain one sub-module, hop_timeout_cnt (loadable down-counter with expire flag), used for REQ-027.

Verification
REQ-034 SHALL cover: two rx_done with rx_data=0x01 then 0x55 (upper bytes 0) -> net_s=0x55, net_en high 1 cycle after the 2nd pulse.
REQ-035 SHALL cover: net_res==net_s on first net_done -> converged=1, iter=1, tx_en 2 cycles later, tx_data=net_res; tx_done -> done pulse, IDLE.
REQ-036 SHALL cover: net_res always differs, MAX_ITER=3 -> exactly 3 net_en rising edges, converged=0, iter=3, then tx_en.
REQ-037 SHALL cover: TIMEOUT=20, net_done withheld -> err=1 at cycle 20 of RUN; abort -> IDLE, err=0.
REQ-038 SHALL cover: rx_done during RUN -> overrun=1 and state_q unchanged; rst_n low mid-WAIT_TX -> all outputs at their reset values immediately.
